// File: rtl/board_debug_io_if.sv
`default_nettype none
// ============================================================================
// board_debug_io_if : debug read port between the board controller and the
//                     CPU data memory (address/enable out, word back).
// Revision: 1.0
// ============================================================================
interface board_debug_io_if #(
  parameter int ADDR_W = 6
);
  logic              read_mem_en;
  logic [ADDR_W-1:0] read_mem_addr;
  logic [31:0]       read_data;

  modport master (
    output read_mem_en,
    output read_mem_addr,
    input  read_data
  );

  modport slave (
    input  read_mem_en,
    input  read_mem_addr,
    output read_data
  );
endinterface
`default_nettype wire

// File: rtl/board_debug_io.sv
`default_nettype none
// ============================================================================
// board_debug_io : button debounce, CPU reset/interrupt/clock-enable control,
//                  halt-and-inspect of data memory and 7-seg hex scan.
//                  Optional feature macro: SINGLE_STEP_EN (btn 2 steps the CPU).
// Revision: 1.0
// ============================================================================
module board_debug_io #(
  parameter int NUM_BTN    = 2,
  parameter int DEB_CYCLES = 100000,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BTN-1:0]    i_btn_raw,
  input  logic [7:0]            i_sw,
  board_debug_io_if.master      dbg,
  output logic                  o_cpu_rst,
  output logic                  o_cpu_clk_en,
  output logic                  o_ext_intr,
  output logic [NUM_BTN-1:0]    o_btn_level,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic [7:0]            o_seg
);

  localparam int c_DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int c_SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int c_IDX_W  = (NUM_DIGITS > 4) ? 3 : 2;

  localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [4:0]          c_STRETCH   = 5'd16;

  localparam logic [1:0] c_ST_RUN     = 2'd0;
  localparam logic [1:0] c_ST_DRAIN   = 2'd1;
  localparam logic [1:0] c_ST_INSPECT = 2'd2;

  logic [NUM_BTN-1:0]              r_sync0;
  logic [NUM_BTN-1:0]              r_sync1;
  logic [NUM_BTN-1:0]              r_btn_level;
  logic [NUM_BTN-1:0]              r_btn_prev;
  logic [NUM_BTN-1:0][c_DEB_W-1:0] r_deb_cnt;
  logic [NUM_BTN-1:0]              w_rise;

  logic [4:0]          r_stretch;
  logic                w_cpu_rst;
  logic                w_clk_en;
  logic                w_step;
  logic                w_step_en;
  logic                r_pend;
  logic                r_sw7_m;
  logic                r_sw7_s;
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_addr_sw;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_disp;
  logic [c_SCAN_W-1:0] r_scan_cnt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [31:0]         w_disp_val;
  logic [4:0]          w_nib_lsb;
  logic [3:0]          w_nib;
  logic                w_dp_on;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]          r_seg;
  logic                w_unused_ok;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0     <= '0;
      r_sync1     <= '0;
      r_btn_level <= '0;
      r_btn_prev  <= '0;
      r_deb_cnt   <= '0;
    end else begin
      r_sync0    <= i_btn_raw;
      r_sync1    <= r_sync0;
      r_btn_prev <= r_btn_level;
      for (int b = 0; b < NUM_BTN; b++) begin
        if (r_sync1[b] == r_btn_level[b]) begin
          r_deb_cnt[b] <= '0;
        end else if (r_deb_cnt[b] == c_DEB_LAST) begin
          r_btn_level[b] <= r_sync1[b];
          r_deb_cnt[b]   <= '0;
        end else begin
          r_deb_cnt[b] <= r_deb_cnt[b] + c_DEB_W'(1);
        end
      end
    end
  end

  assign w_rise = r_btn_level & ~r_btn_prev;

  always_ff @(posedge clk) begin
    if (rst || r_btn_level[0]) begin
      r_stretch <= c_STRETCH;
    end else if (r_stretch != 5'd0) begin
      r_stretch <= r_stretch - 5'd1;
    end
  end

  assign w_cpu_rst = rst | r_btn_level[0] | (r_stretch != 5'd0);

`ifdef SINGLE_STEP_EN
  generate
    if (NUM_BTN >= 3) begin : g_step
      assign w_step = w_rise[2];
    end else begin : g_no_step
      assign w_step = 1'b0;
    end
  endgenerate
`else
  assign w_step = 1'b0;
`endif

  assign w_step_en = w_step & (r_state == c_ST_INSPECT);
  assign w_clk_en  = ~w_cpu_rst & ((r_state == c_ST_RUN) | w_step_en);

  // A rise landing in the delivery cycle re-arms the flag for a later delivery.
  always_ff @(posedge clk) begin
    if (rst || w_cpu_rst) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_rise[1] | (r_pend & ~w_clk_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw7_m <= 1'b0;
      r_sw7_s <= 1'b0;
    end else begin
      r_sw7_m <= i_sw[7];
      r_sw7_s <= r_sw7_m;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:     if (r_sw7_s) w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN:   w_state_nxt = c_ST_INSPECT;
      c_ST_INSPECT: if (!r_sw7_s) w_state_nxt = c_ST_RUN;
      default:      w_state_nxt = c_ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  generate
    if (ADDR_W > 6) begin : g_addr_wide
      assign w_addr_sw = {{(ADDR_W-6){1'b0}}, i_sw[6:1]};
    end else begin : g_addr_narrow
      assign w_addr_sw = i_sw[ADDR_W:1];
    end
  endgenerate

  assign w_rd_en = (r_state == c_ST_INSPECT) & r_sw7_s;

  // Address also loads during DRAIN so the first INSPECT read is already valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_disp <= '0;
    end else begin
      if (r_state != c_ST_RUN) r_addr <= w_addr_sw;
      if (w_rd_en)             r_disp <= dbg.read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == c_SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
    end
  end

  generate
    if (NUM_DIGITS == 8) begin : g_disp8
      assign w_disp_val = r_disp;
    end else begin : g_disp4
      assign w_disp_val = {16'h0000, (i_sw[0] ? r_disp[31:16] : r_disp[15:0])};
    end
  endgenerate

  assign w_nib_lsb = 5'({r_idx, 2'b00});
  assign w_nib     = w_disp_val[w_nib_lsb +: 4];
  assign w_dp_on   = (r_state == c_ST_INSPECT) && (r_idx == '0);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= {~w_dp_on, hex7(w_nib)};
    end
  end

  assign w_unused_ok = ^{w_rise, i_sw};

  assign dbg.read_mem_en   = w_rd_en;
  assign dbg.read_mem_addr = r_addr;
  assign o_cpu_rst         = w_cpu_rst;
  assign o_cpu_clk_en      = w_clk_en;
  assign o_ext_intr        = r_pend & w_clk_en;
  assign o_btn_level       = r_btn_level;
  assign o_an              = r_an;
  assign o_seg             = r_seg;

endmodule
`default_nettype wire
